// File: rtl/approx_adder_error_monitor.sv
// Error monitor for the approximate prefix adder: recomputes the exact sum per
// sample and accumulates error count, max and summed error distance over a window.
module approx_adder_error_monitor #(
   parameter int WIDTH        = 16,
   parameter int LOG2_SAMPLES = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH-1:0]               op_a,
   input  logic [WIDTH-1:0]               op_b,
   input  logic [WIDTH:0]                 approx_res,
   output logic                           busy,
   output logic                           done,
   output logic [LOG2_SAMPLES:0]          err_count,
   output logic [WIDTH:0]                 max_ed,
   output logic [WIDTH+LOG2_SAMPLES:0]    sum_ed
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [LOG2_SAMPLES:0] CNT_LAST = {1'b0, {LOG2_SAMPLES{1'b1}}};

   state_t                  state, state_n;
   logic [LOG2_SAMPLES:0]   sample_cnt;
   logic                    s1_valid, s2_valid;
   logic [WIDTH:0]          s1_ed;
   logic [WIDTH:0]          exact;
   logic [WIDTH+1:0]        diff;
   logic [WIDTH:0]          ed;
   logic                    accept;
   logic                    clear;

   assign in_ready = (state == RUN);
   assign busy     = (state == RUN) || (state == DRAIN);
   assign done     = (state == DONE);
   assign accept   = in_valid && in_ready;
   assign clear    = start && ((state == IDLE) || (state == DONE));

   // Sign comes from one extra bit; magnitude recomputed in WIDTH+1 bits to avoid negation.
   always_comb begin
      exact = {1'b0, op_a} + {1'b0, op_b};
      diff  = {1'b0, exact} - {1'b0, approx_res};
      ed    = diff[WIDTH+1] ? (approx_res - exact) : diff[WIDTH:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:  if (start) state_n = RUN;
         RUN:   if (accept && (sample_cnt == CNT_LAST)) state_n = DRAIN;
         DRAIN: if (!s1_valid && !s2_valid) state_n = DONE;
         DONE:  if (start) state_n = RUN;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_cnt <= '0;
         s1_valid   <= 1'b0;
         s1_ed      <= '0;
         s2_valid   <= 1'b0;
         err_count  <= '0;
         max_ed     <= '0;
         sum_ed     <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) s1_ed <= ed;
         s2_valid <= s1_valid;
         if (clear) begin
            sample_cnt <= '0;
            err_count  <= '0;
            max_ed     <= '0;
            sum_ed     <= '0;
         end else begin
            if (accept) sample_cnt <= sample_cnt + 1'b1;
            if (s1_valid) begin
               sum_ed <= sum_ed + {{LOG2_SAMPLES{1'b0}}, s1_ed};
               if (s1_ed > max_ed) max_ed <= s1_ed;
               if (s1_ed != '0) err_count <= err_count + 1'b1;
            end
         end
      end
   end

endmodule
